// File: rtl/jtdsp16_pbus_host.sv
// jtdsp16_pbus_host: external-device end of the DSP16 parallel port in active mode.
// The DSP owns the strobes (pods_n / pids_n); this block reacts to their falling
// edges. DSP output words go into an RX FIFO that the host drains. Host words
// go into a TX FIFO whose head is always presented on pbus_out.
//
// Ports:
//   clk, rst              single clock, async active-high reset
//   pbus_in, psel         DSP output data and peripheral select (PDX0/PDX1)
//   pbus_out              TX FIFO head, registered (0 when empty)
//   pods_n, pids_n        DSP output/input data strobes, active low
//   host_addr/din/we/rd   host access: 0 status, 1 RX data, 2 TX data, 3 control
//   host_dout             host read data, combinational on host_addr
//   host_irq, dsp_irq     registered interrupt requests
module jtdsp16_pbus_host #(
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pbus_in,
  output logic [15:0] pbus_out,
  input  logic        pods_n,
  input  logic        pids_n,
  input  logic        psel,
  input  logic [15:0] host_din,
  output logic [15:0] host_dout,
  input  logic [1:0]  host_addr,
  input  logic        host_we,
  input  logic        host_rd,
  output logic        host_irq,
  output logic        dsp_irq
);

  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [16:0]   rx_mem_q [0:(1<<AW)-1];
  logic [15:0]   tx_mem_q [0:(1<<AW)-1];

  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          pods_q, pids_q, arm_q;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic          last_psel_q, last_psel_d;
  logic [15:0]   pbus_out_q, pbus_out_d;
  logic          host_irq_q, dsp_irq_q;

  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          pods_fall, pids_fall;
  logic          rx_push, rx_pop, tx_push, tx_pop, stat_clr;
  logic [16:0]   rx_head;
  logic [15:0]   status;

  // arm_q masks the first cycle after reset so a strobe already low at
  // release is not mistaken for a fall.
  assign pods_fall = arm_q & pods_q & ~pods_n;
  assign pids_fall = arm_q & pids_q & ~pids_n;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = rx_cnt_q[AW];
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = tx_cnt_q[AW];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is popped simultaneously.
  assign rx_pop   = host_rd & (host_addr == 2'd1) & ~rx_empty;
  assign rx_push  = pods_fall & (~rx_full | rx_pop);
  assign tx_pop   = pids_fall & ~tx_empty;
  assign tx_push  = host_we & (host_addr == 2'd2) & (~tx_full | tx_pop);
  assign stat_clr = host_rd & (host_addr == 2'd0);

  assign rx_head = rx_empty ? 17'd0 : rx_mem_q[rx_rd_q];
  assign status  = {8'h00, last_psel_q, rx_head[16], tx_unf_q, rx_ovf_q,
                    tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    host_dout = 16'h0000;
    case (host_addr)
      2'd0:    host_dout = status;
      2'd1:    host_dout = rx_head[15:0];
      2'd2:    host_dout = pbus_out_q;
      default: host_dout = {14'd0, ctrl_q};
    endcase
  end

  always_comb begin
    rx_wr_d     = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
    rx_rd_d     = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
    tx_wr_d     = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
    tx_rd_d     = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CNT_ONE;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CNT_ONE;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;

    // Set wins over a same-cycle status-read clear.
    rx_ovf_d    = (rx_ovf_q & ~stat_clr) | (pods_fall & rx_full & ~rx_pop);
    tx_unf_d    = (tx_unf_q & ~stat_clr) | (pids_fall & tx_empty);
    last_psel_d = pids_fall ? psel : last_psel_q;
    ctrl_d      = (host_we && host_addr == 2'd3) ? host_din[1:0] : ctrl_q;

    // The DSP samples pbus_out on the same edge its strobe falls, so the next
    // head is precomputed; a word written into the slot that becomes the head
    // this cycle is forwarded because the memory write is not visible yet.
    if (tx_cnt_d == '0)
      pbus_out_d = 16'h0000;
    else if (tx_push && tx_wr_q == tx_rd_d)
      pbus_out_d = host_din;
    else
      pbus_out_d = tx_mem_q[tx_rd_d];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= {psel, pbus_in};
    if (tx_push) tx_mem_q[tx_wr_q] <= host_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      pods_q      <= 1'b1;
      pids_q      <= 1'b1;
      arm_q       <= 1'b0;
      ctrl_q      <= 2'b00;
      rx_ovf_q    <= 1'b0;
      tx_unf_q    <= 1'b0;
      last_psel_q <= 1'b0;
      pbus_out_q  <= 16'h0000;
      host_irq_q  <= 1'b0;
      dsp_irq_q   <= 1'b0;
    end else begin
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      pods_q      <= pods_n;
      pids_q      <= pids_n;
      arm_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_unf_q    <= tx_unf_d;
      last_psel_q <= last_psel_d;
      pbus_out_q  <= pbus_out_d;
      // Interrupts follow the current FIFO state, one cycle behind it.
      host_irq_q  <= ctrl_q[0] & ~rx_empty;
      dsp_irq_q   <= ctrl_q[1] & ~tx_empty;
    end
  end

  assign pbus_out = pbus_out_q;
  assign host_irq = host_irq_q;
  assign dsp_irq  = dsp_irq_q;

endmodule

// File: tb/tb_jtdsp16_pbus_host.sv
module tb_jtdsp16_pbus_host;

  localparam int K_DOUT = 0;
  localparam int K_PBUS = 1;
  localparam int K_HIRQ = 2;
  localparam int K_DIRQ = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pbus_in = 16'h0000;
  logic [15:0] pbus_out;
  logic        pods_n = 1'b1;
  logic        pids_n = 1'b1;
  logic        psel = 1'b0;
  logic [15:0] host_din = 16'h0000;
  logic [15:0] host_dout;
  logic [1:0]  host_addr = 2'd0;
  logic        host_we = 1'b0;
  logic        host_rd = 1'b0;
  logic        host_irq;
  logic        dsp_irq;
  logic        probe = 1'b0;

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] act;
  int          total = 0;
  int          bad = 0;

  jtdsp16_pbus_host #(.AW(2)) dut (
    .clk(clk), .rst(rst), .pbus_in(pbus_in), .pbus_out(pbus_out),
    .pods_n(pods_n), .pids_n(pids_n), .psel(psel),
    .host_din(host_din), .host_dout(host_dout), .host_addr(host_addr),
    .host_we(host_we), .host_rd(host_rd),
    .host_irq(host_irq), .dsp_irq(dsp_irq)
  );

  always #5 clk = ~clk;

  // Monitor: whenever the bench presents a host read or a probe, the DUT
  // output is taken on the falling edge and matched against the queue head.
  always @(negedge clk) begin
    if (!rst && (host_rd || probe)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got dout=%h with no expectation queued", host_dout);
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_DOUT:  act = host_dout;
          K_PBUS:  act = pbus_out;
          K_HIRQ:  act = {15'd0, host_irq};
          default: act = {15'd0, dsp_irq};
        endcase
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [15:0] v, input string nm);
    exp_t x;
    x.kind = kind;
    x.val  = v;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic hrd(input logic [1:0] a, input logic [15:0] v, input string nm);
    expect_val(K_DOUT, v, nm);
    host_addr = a;
    host_rd   = 1'b1;
    step();
    host_rd   = 1'b0;
  endtask

  task automatic hwr(input logic [1:0] a, input logic [15:0] d);
    host_addr = a;
    host_din  = d;
    host_we   = 1'b1;
    step();
    host_we   = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [15:0] v, input string nm);
    expect_val(kind, v, nm);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic pods_pulse(input logic ps, input logic [15:0] d, input int len);
    psel    = ps;
    pbus_in = d;
    pods_n  = 1'b0;
    repeat (len) step();
    pods_n  = 1'b1;
    step();
  endtask

  task automatic pids_pulse(input logic ps, input int len);
    psel   = ps;
    pids_n = 1'b0;
    repeat (len) step();
    pids_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();

    // reset state
    hrd(0, 16'h0005, "rst_status");
    chk(K_PBUS, 16'h0000, "rst_pbus_out");
    chk(K_HIRQ, 16'h0000, "rst_host_irq");
    chk(K_DIRQ, 16'h0000, "rst_dsp_irq");
    hrd(3, 16'h0000, "rst_control");

    // DSP -> host single word on PDX1
    pods_pulse(1'b1, 16'h1234, 2);
    hrd(0, 16'h0044, "rx1_status");
    hrd(1, 16'h1234, "rx1_data");
    hrd(0, 16'h0005, "rx1_status_after_pop");

    // host -> DSP two words
    hwr(2, 16'hA001);
    hwr(2, 16'hA002);
    chk(K_PBUS, 16'hA001, "tx_head_a001");
    hrd(2, 16'hA001, "tx_head_read");
    pids_pulse(1'b0, 1);
    chk(K_PBUS, 16'hA002, "tx_head_a002");
    pids_pulse(1'b1, 1);
    chk(K_PBUS, 16'h0000, "tx_drained_pbus");
    hrd(0, 16'h0085, "tx_status_last_psel");

    // RX overflow with varied strobe lengths
    for (int i = 1; i <= 5; i++) pods_pulse(1'b0, 16'(i), (i % 4) + 1);
    hrd(0, 16'h0096, "rx_full_ovf_status");
    hrd(0, 16'h0086, "rx_ovf_cleared");
    for (int i = 1; i <= 4; i++) hrd(1, 16'(i), $sformatf("rx_ovf_data%0d", i));
    hrd(0, 16'h0085, "rx_drained_status");

    // TX underflow
    pids_pulse(1'b1, 1);
    chk(K_PBUS, 16'h0000, "unf_pbus");
    hrd(0, 16'h00A5, "unf_status");
    hrd(0, 16'h0085, "unf_cleared");

    // interrupts
    hwr(3, 16'h0003);
    hrd(3, 16'h0003, "ctrl_read");
    hwr(2, 16'h5555);
    step();
    chk(K_DIRQ, 16'h0001, "dsp_irq_set");
    pids_pulse(1'b0, 1);
    chk(K_DIRQ, 16'h0000, "dsp_irq_clear");
    pods_pulse(1'b1, 16'hBEEF, 1);
    chk(K_HIRQ, 16'h0001, "host_irq_set");
    hrd(1, 16'hBEEF, "irq_rx_data");
    step();
    chk(K_HIRQ, 16'h0000, "host_irq_clear");
    hrd(0, 16'h0005, "irq_status");

    // same-cycle RX push and pop with one entry held
    pods_pulse(1'b0, 16'h0111, 1);
    expect_val(K_DOUT, 16'h0111, "collide_old_head");
    host_addr = 2'd1;
    host_rd   = 1'b1;
    pbus_in   = 16'h0222;
    psel      = 1'b0;
    pods_n    = 1'b0;
    step();
    host_rd   = 1'b0;
    pods_n    = 1'b1;
    step();
    hrd(0, 16'h0004, "collide_status");
    hrd(1, 16'h0222, "collide_new_head");
    hrd(0, 16'h0005, "collide_drained");

    // TX full: fifth word dropped, no underflow flag
    for (int i = 0; i < 5; i++) hwr(2, 16'h0010 + 16'(i));
    hrd(0, 16'h0009, "tx_full_status");
    chk(K_DIRQ, 16'h0001, "tx_full_dsp_irq");
    for (int i = 0; i < 4; i++) begin
      chk(K_PBUS, 16'h0010 + 16'(i), $sformatf("tx_full_head%0d", i));
      pids_pulse(1'b0, 1);
    end
    chk(K_PBUS, 16'h0000, "tx_full_drained");
    hrd(0, 16'h0005, "tx_full_drained_status");

    // reset mid-operation with pods_n held low across release
    hwr(2, 16'h7777);
    pbus_in = 16'h3333;
    pods_n  = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst     = 1'b0;
    step();
    step();
    pods_n  = 1'b1;
    step();
    hrd(0, 16'h0005, "midrst_status");
    chk(K_PBUS, 16'h0000, "midrst_pbus");
    hrd(3, 16'h0000, "midrst_ctrl");
    pods_pulse(1'b0, 16'h4444, 1);
    hrd(1, 16'h4444, "postrst_rx");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtdsp16_pbus_host.md
Name: jtdsp16_pbus_host

Overview:
- External-device end of the DSP16 parallel port, running in active mode: the DSP drives the pods_n and pids_n strobes, and this block responds to them.
- DSP→host path: DSP output words are captured into an RX FIFO that the host drains.
- Host→DSP path: host words are queued in a TX FIFO, and its head is presented continuously on the DSP input bus.
- Sits between the DSP16 core and a host CPU (e.g. a Z80 sound latch side). It raises interrupts in both directions.

Parameters:
- AW, 2, FIFO address width; each FIFO holds 2**AW entries.

Ports:
- clk  in  1  system clock; the single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- pbus_in  in  16  DSP parallel bus output (DSP pbus_out).
- pbus_out  out  16  data presented to the DSP parallel bus input (DSP pbus_in).
- pods_n  in  1  DSP output data strobe, active low.
- pids_n  in  1  DSP input data strobe, active low.
- psel  in  1  DSP peripheral select (0=PDX0, 1=PDX1).
- host_din  in  16  host write data.
- host_dout  out  16  host read data, combinational.
- host_addr  in  2  0=status, 1=RX data, 2=TX data, 3=control.
- host_we  in  1  host write strobe, one cycle per access.
- host_rd  in  1  host read strobe, one cycle per access.
- host_irq  out  1  interrupt to host.
- dsp_irq  out  1  interrupt to the DSP irq input.

Behaviour:
- Reset (async): both FIFOs empty, all pointers 0, control=0, sticky flags 0, last_psel 0, previous-strobe registers 1.
  - Output reset values: pbus_out=0, host_irq=0, dsp_irq=0.
- Strobe detection: pods_n and pids_n are registered each cycle. A fall is a cycle where the registered value is 1 and the current value is 0. Only falls act; low pulses of 1–4 cycles count as one event. A continuously low strobe (back-to-back DSP accesses) yields one event only; this limitation is documented.
- RX push: on a pods_n fall, write {psel, pbus_in} into the RX FIFO in that same cycle. The DSP drives data and psel valid in the first low cycle.
  - If RX is full: the word is dropped and sticky rx_ovf is set.
- TX presentation: the DSP samples pbus_in at the same edge its strobe falls, before the strobe is visible here. Therefore pbus_out is registered and always equals the TX FIFO head (0 when empty), independent of psel.
- TX pop: on a pids_n fall, pop the TX FIFO and capture psel into last_psel. pbus_out updates to the next head one cycle later.
  - If TX is empty: no pop, sticky tx_unf is set, pbus_out stays 0.
- Host reads (host_dout is combinational on host_addr):
  - addr0 status: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_ovf, bit5 tx_unf, bit6 psel of RX head, bit7 last_psel, bits15:8 = 0. A host_rd at addr0 clears rx_ovf and tx_unf at the clock edge.
  - addr1: RX head data (0 when empty). host_rd pops one entry; a pop when empty has no effect.
  - addr2 / addr3: return TX head / control.
- Host writes:
  - addr2 pushes host_din into TX; when TX is full the word is dropped and tx_unf is unaffected.
  - addr3 writes control[1:0]: bit0 = host rx irq enable, bit1 = dsp tx irq enable.
  - Writes to addr0 or addr1 are ignored.
- Simultaneous push and pop on the same FIFO:
  - Not empty: both occur and the count is unchanged (also when full).
  - Empty: the pop is ignored and the pushed data becomes visible next cycle.
- Set/clear collision: a sticky set event coinciding with a status-read clear leaves the flag set.
- FIFO bookkeeping: AW-bit pointers wrap modulo 2**AW; the count is AW+1 bits wide.
- Interrupts (registered): host_irq = control[0] & !rx_empty; dsp_irq = control[1] & !tx_empty. Each is updated one cycle after the FIFO state changes.
- Mid-operation reset: contents are discarded immediately; a strobe that is low while rst releases is not counted as a fall.

Test Plan:
- Reset, then pods_n low for 2 cycles with psel=1 and pbus_in=16'h1234 → status bit0=0 and bit6=1; host read of addr1 returns 16'h1234; pop → status returns 16'h0005 (rx_empty, tx_empty).
- Host pushes 16'hA001 and 16'hA002 to addr2 → pbus_out=16'hA001. One pids_n fall with psel=0 → pbus_out=16'hA002 a cycle later. Second fall with psel=1 → pbus_out=0 and status bit7=1.
- Five pods_n pulses (data 1..5) with no host reads and AW=2 → rx_full=1, rx_ovf=1; reads return 1,2,3,4. The status read clears bit4.
- pids_n fall with TX empty → tx_unf=1, pbus_out stays 0, no pointer change.
- control=3, host writes to TX → dsp_irq=1 until TX drains; a pods_n capture → host_irq=1, which drops after the host pop.
- Same cycle: RX holding 1 entry, a pods_n fall plus host_rd of addr1 → count stays 1, and the head becomes the new word.
